// File: rtl/as_pack.sv
// Shared JTAG definitions: DR capture modes and IDCODE/USERCODE constants.
package as_pack;

    typedef enum logic {
        DR_CAP_PARALLEL,
        DR_CAP_CONST
    } dr_cap_mode_t;

    function automatic logic [31:0] mk_idcode(
        input logic [3:0]  ver,
        input logic [15:0] part,
        input logic [10:0] mfr
    );
        return {ver, part, mfr, 1'b1};
    endfunction

    localparam logic [31:0] IDCODE_VAL   = mk_idcode(4'h1, 16'hBA00, 11'h23B);
    localparam logic [31:0] USERCODE_VAL = 32'h0000_0000;

endpackage

// File: rtl/jtag_dr_len_chk.sv
// Saturating shift-bit counter and length compare for a JTAG data register.
// Only instantiated when JTAG_DR_LEN_CHECK_EN is defined.
module jtag_dr_len_chk #(
    parameter int WIDTH = 32
) (
    input  logic tck_i,
    input  logic trst_i,
    input  logic i_cap,
    input  logic i_shift,
    input  logic i_upd,
    output logic o_len_ok,
    output logic o_len_err
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] L_LEN = CW'(WIDTH);
    localparam logic [CW-1:0] L_SAT = CW'(WIDTH + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_cap) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_shift) begin
            if (r_cnt != L_SAT) r_cnt <= r_cnt + 1'b1;
        end else if (i_upd && (r_cnt != L_LEN)) begin
            r_err <= 1'b1;
        end
    end

    assign o_len_ok  = (r_cnt == L_LEN);
    assign o_len_err = r_err;

endmodule

// File: rtl/jtag_data_reg.sv
// Parametrised JTAG test data register: capture, LSB-first shift, update.
// Define JTAG_DR_LEN_CHECK_EN to reject updates after a wrong shift length.
module jtag_data_reg
    import as_pack::*;
#(
    parameter int                 WIDTH    = 32,
    parameter dr_cap_mode_t       CAP_MODE = DR_CAP_PARALLEL,
    parameter logic [WIDTH-1:0]   CAP_VAL  = '0,
    parameter logic [WIDTH-1:0]   RST_VAL  = '0
) (
    input  logic             tck_i,
    input  logic             trst_i,
    input  logic             sel_i,
    input  logic             capture_dr_i,
    input  logic             shift_dr_i,
    input  logic             update_dr_i,
    input  logic             tdi_i,
    output logic             tdo_o,
    input  logic [WIDTH-1:0] par_i,
    output logic [WIDTH-1:0] par_o,
    output logic             upd_o,
    output logic             len_err_o
);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_par;
    logic             r_upd;

    logic             w_cap;
    logic             w_shift;
    logic             w_upd;
    logic             w_len_ok;
    logic [WIDTH-1:0] w_cap_src;

    // Fixed priority capture > shift > update, all gated by select
    assign w_cap   = sel_i & capture_dr_i;
    assign w_shift = sel_i & shift_dr_i & ~capture_dr_i;
    assign w_upd   = sel_i & update_dr_i & ~capture_dr_i & ~shift_dr_i;

    assign w_cap_src = (CAP_MODE == DR_CAP_CONST) ? CAP_VAL : par_i;

`ifdef JTAG_DR_LEN_CHECK_EN
    jtag_dr_len_chk #(
        .WIDTH (WIDTH)
    ) u_len_chk (
        .tck_i     (tck_i),
        .trst_i    (trst_i),
        .i_cap     (w_cap),
        .i_shift   (w_shift),
        .i_upd     (w_upd),
        .o_len_ok  (w_len_ok),
        .o_len_err (len_err_o)
    );
`else
    assign w_len_ok  = 1'b1;
    assign len_err_o = 1'b0;
`endif

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            r_shift <= '0;
        end else if (w_cap) begin
            r_shift <= w_cap_src;
        end else if (w_shift) begin
            r_shift <= {tdi_i, r_shift[WIDTH-1:1]};
        end
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            r_par <= RST_VAL;
            r_upd <= 1'b0;
        end else begin
            r_upd <= w_upd & w_len_ok;
            if (w_upd && w_len_ok) r_par <= r_shift;
        end
    end

    assign tdo_o = r_shift[0];
    assign par_o = r_par;
    assign upd_o = r_upd;

endmodule

// File: tb/tb_jtag_data_reg.sv
// Self-checking bench for jtag_data_reg: vector table, corner sequences, random vs model.
module tb_jtag_data_reg;
    import as_pack::*;

`ifdef JTAG_DR_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        tck = 1'b0;
    logic        trst, sel_a, sel_b, cap, shf, upd, tdi;
    logic [7:0]  par_a;
    logic [31:0] par_b;
    logic        tdo_a, upd_a, err_a;
    logic [7:0]  pa_o;
    logic        tdo_b, upd_b, err_b;
    logic [31:0] pb_o;

    always #5 tck = ~tck;

    jtag_data_reg #(
        .WIDTH(8), .CAP_MODE(DR_CAP_PARALLEL),
        .CAP_VAL(8'h00), .RST_VAL(8'hA5)
    ) dut_a (
        .tck_i(tck), .trst_i(trst), .sel_i(sel_a),
        .capture_dr_i(cap), .shift_dr_i(shf), .update_dr_i(upd),
        .tdi_i(tdi), .tdo_o(tdo_a), .par_i(par_a), .par_o(pa_o),
        .upd_o(upd_a), .len_err_o(err_a)
    );

    jtag_data_reg #(
        .WIDTH(32), .CAP_MODE(DR_CAP_CONST),
        .CAP_VAL(IDCODE_VAL), .RST_VAL(32'h0)
    ) dut_b (
        .tck_i(tck), .trst_i(trst), .sel_i(sel_b),
        .capture_dr_i(cap), .shift_dr_i(shf), .update_dr_i(upd),
        .tdi_i(tdi), .tdo_o(tdo_b), .par_i(par_b), .par_o(pb_o),
        .upd_o(upd_b), .len_err_o(err_b)
    );

    int checks = 0;
    int failures = 0;

    // Reference model of the 8-bit instance
    logic [7:0] m_sh, m_par;
    bit         m_upd, m_err;
    int         m_cnt;

    typedef struct {
        bit       c, s, u, t;
        logic [7:0] p;
        bit       e_tdo;
        logic [7:0] e_par;
        bit       e_upd;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_sh = 8'h00; m_par = 8'hA5; m_upd = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic check_a(input string tag);
        chk({tag, ".tdo"}, {31'd0, tdo_a}, {31'd0, m_sh[0]});
        chk({tag, ".par"}, {24'd0, pa_o}, {24'd0, m_par});
        chk({tag, ".upd"}, {31'd0, upd_a}, {31'd0, m_upd});
        chk({tag, ".err"}, {31'd0, err_a}, {31'd0, m_err});
    endtask

    task automatic model_edge(input bit s, input bit c, input bit sh, input bit u,
                              input bit t, input logic [7:0] p);
        m_upd = 0;
        if (s) begin
            if (c) begin
                m_sh = p; m_cnt = 0; m_err = 0;
            end else if (sh) begin
                m_sh = (m_sh >> 1) + (t ? 8'h80 : 8'h00);
                m_cnt = (m_cnt < 9) ? m_cnt + 1 : 9;
            end else if (u) begin
                if (!CHK || m_cnt == 8) begin
                    m_par = m_sh; m_upd = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic step(input string tag, input bit sa, input bit sb, input bit c,
                        input bit sh, input bit u, input bit t, input logic [7:0] p);
        sel_a = sa; sel_b = sb; cap = c; shf = sh; upd = u; tdi = t;
        par_a = p; par_b = $urandom;
        model_edge(sa, c, sh, u, t, p);
        @(posedge tck); #1;
        check_a(tag);
    endtask

    task automatic async_reset(input string tag);
        trst = 1'b1;
        #1;
        m_reset();
        check_a(tag);
        chk({tag, ".tdo_b"}, {31'd0, tdo_b}, 32'd0);
        chk({tag, ".par_b"}, pb_o, 32'd0);
        #1 trst = 1'b0;
    endtask

    logic [31:0] word_out, word_in;
    logic [7:0]  tdi_pat;

    initial begin
        trst = 0; sel_a = 0; sel_b = 0; cap = 0; shf = 0; upd = 0; tdi = 0;
        par_a = 0; par_b = 0;
        m_reset();
        #2;
        async_reset("rst0");

        // Capture 3C, shift 1,0,1,0,1,0,1,0, update, idle
        tdi_pat = 8'b0101_0101;
        vt[0] = '{1, 0, 0, 0, 8'h3C, 0, 8'hA5, 0};
        for (int i = 0; i < 8; i++) begin
            vt[i+1] = '{0, 1, 0, tdi_pat[i], 8'h00, 0, 8'hA5, 0};
        end
        vt[2].e_tdo = 1; vt[3].e_tdo = 1; vt[4].e_tdo = 1;
        vt[5].e_tdo = 1; vt[8].e_tdo = 1;
        vt[9]  = '{0, 0, 1, 0, 8'h00, 1, 8'h55, 1};
        vt[10] = '{0, 0, 0, 0, 8'h00, 1, 8'h55, 0};
        for (int i = 0; i < 11; i++) begin
            step("vec", 1, 0, vt[i].c, vt[i].s, vt[i].u, vt[i].t, vt[i].p);
            chk($sformatf("vec%0d.tdo", i), {31'd0, tdo_a}, {31'd0, vt[i].e_tdo});
            chk($sformatf("vec%0d.par", i), {24'd0, pa_o}, {24'd0, vt[i].e_par});
            chk($sformatf("vec%0d.upd", i), {31'd0, upd_a}, {31'd0, vt[i].e_upd});
        end

        // Reset mid-shift returns par_o to A5
        step("pre_rst", 1, 0, 1, 0, 0, 0, 8'hFF);
        step("pre_rst", 1, 0, 0, 1, 0, 1, 8'h00);
        step("pre_rst", 1, 0, 0, 1, 0, 0, 8'h00);
        async_reset("rst_mid");
        chk("rst_mid.par_a5", {24'd0, pa_o}, 32'h0000_00A5);

        // Constant capture on the 32-bit IDCODE instance
        step("idc_cap", 0, 1, 1, 0, 0, 0, 8'h00);
        word_in = $urandom;
        for (int i = 0; i < 32; i++) begin
            word_out[i] = tdo_b;
            step("idc_sh", 0, 1, 0, 1, 0, word_in[i], 8'h00);
        end
        chk("idc.stream", word_out, IDCODE_VAL);
        step("idc_upd", 0, 1, 0, 0, 1, 0, 8'h00);
        chk("idc.par", pb_o, word_in);
        chk("idc.upd", {31'd0, upd_b}, 32'd1);
        chk("idc.err", {31'd0, err_b}, 32'd0);
        step("idc_upd2", 0, 1, 0, 0, 1, 0, 8'h00);
        chk("idc.upd2", {31'd0, upd_b}, 32'd1);
        step("idc_idle", 0, 1, 0, 0, 0, 0, 8'h00);
        chk("idc.idle", {31'd0, upd_b}, 32'd0);

        // Deselected strobes change nothing
        step("desel", 0, 0, 1, 0, 0, 0, 8'hC3);
        step("desel", 0, 0, 0, 1, 0, 1, 8'h00);
        step("desel", 0, 0, 0, 0, 1, 0, 8'h00);
        chk("desel.par_b", pb_o, word_in);
        chk("desel.upd_b", {31'd0, upd_b}, 32'd0);

        // Short shift (7 bits)
        step("len7", 1, 0, 1, 0, 0, 0, 8'h96);
        for (int i = 0; i < 7; i++) step("len7", 1, 0, 0, 1, 0, 1, 8'h00);
        step("len7_upd", 1, 0, 0, 0, 1, 0, 8'h00);
        chk("len7.err_exp", {31'd0, err_a}, {31'd0, CHK});
        // Long shift (9 bits)
        step("len9", 1, 0, 1, 0, 0, 0, 8'h69);
        for (int i = 0; i < 9; i++) step("len9", 1, 0, 0, 1, 0, i[0], 8'h00);
        step("len9_upd", 1, 0, 0, 0, 1, 0, 8'h00);
        chk("len9.err_exp", {31'd0, err_a}, {31'd0, CHK});
        step("len_clr", 1, 0, 1, 0, 0, 0, 8'h11);
        chk("len_clr.err", {31'd0, err_a}, 32'd0);

        // Capture and shift together: capture wins, counter restarts
        step("simul", 1, 0, 1, 1, 0, 1, 8'hE7);
        for (int i = 0; i < 8; i++) step("simul", 1, 0, 0, 1, 0, 0, 8'h00);
        step("simul_upd", 1, 0, 0, 0, 1, 0, 8'h00);
        chk("simul.upd", {31'd0, upd_a}, 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            bit c, s, u;
            r = $urandom_range(0, 11);
            c = (r == 4 || r == 7 || r == 9);
            s = (r <= 3 || r == 7 || r == 8 || r == 9 || r == 10);
            u = (r == 5 || r == 8 || r == 9 || r == 11);
            step("rnd", ($urandom_range(0, 3) != 0), 0, c, s, u,
                 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 59) == 0) async_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_data_reg.md
# jtag_data_reg

Parametrised JTAG test data register with capture, shift and update stages, for user DRs, IDCODE and wide control registers. It sits behind the TAP controller's IR decoder, which drives its select and stage strobes. It is clocked entirely in the TCK domain. Its serial output feeds the TDO multiplexer alongside the bypass register.

## Interface
Parameters:
- WIDTH, 32: register length in bits (≥2).
- CAP_MODE, DR_CAP_PARALLEL: capture source, either DR_CAP_PARALLEL (par_i) or DR_CAP_CONST (CAP_VAL).
- CAP_VAL, '0: constant loaded on capture when CAP_MODE = DR_CAP_CONST.
- RST_VAL, '0: reset value of the update register par_o.

Ports:
- tck_i  in  1  TAP clock; all state updates on the rising edge.
- trst_i  in  1  TAP reset, asynchronous, active-high.
- sel_i  in  1  this DR is selected by the current instruction.
- capture_dr_i  in  1  TAPC in Capture-DR.
- shift_dr_i  in  1  TAPC in Shift-DR.
- update_dr_i  in  1  TAPC in Update-DR.
- tdi_i  in  1  serial data in.
- tdo_o  out  1  serial data out, equal to shift[0] (combinational from the register).
- par_i  in  WIDTH  parallel capture data.
- par_o  out  WIDTH  update (shadow) register.
- upd_o  out  1  one-cycle pulse after par_o is written.
- len_err_o  out  1  sticky shift-length error (see Configuration).

## Operation
- Reset values: shift register = 0, par_o = RST_VAL, upd_o = 0, len_err_o = 0, shift counter = 0.
- With sel_i = 0, all internal state holds and upd_o = 0.
- Stage strobes are decoded with fixed priority: capture > shift > update. The TAPC asserts at most one strobe, and the priority only defines behaviour if several arrive together.
- Capture: shift ← par_i, or CAP_VAL when CAP_MODE is DR_CAP_CONST. The shift counter clears to 0 and len_err_o clears.
- Shift: shift ← {tdi_i, shift[WIDTH-1:1]}, LSB first. The counter increments and saturates at WIDTH+1.
- Update: par_o ← shift and upd_o = 1 for the following cycle, subject to the length check when that check is compiled in. The shift register is unchanged.
- Reset asserted mid-shift or mid-update returns all state to reset values immediately. The next transaction requires a fresh capture.

## Timing
- Capture to first valid tdo_o: tdo_o shows the captured bit 0 after the capture edge. The TDO stage provides the falling-edge retime.
- WIDTH shift edges move the full captured word out and the full TDI word in.
- Update: par_o is valid 1 tck after the update edge, and upd_o is high for exactly that cycle.
- Consecutive update strobes each produce a pulse and rewrite the same value.

## Configuration
- JTAG_DR_LEN_CHECK_EN defined:
  - At update, if the counter ≠ WIDTH (too few bits, or saturated at WIDTH+1), par_o holds, upd_o stays 0, and len_err_o is set.
  - len_err_o stays set until the next capture or reset.
- JTAG_DR_LEN_CHECK_EN undefined:
  - The counter is not instantiated.
  - Every selected update writes par_o and pulses upd_o.
  - len_err_o is tied to 0.

## Structure
- as_pack gains typedef enum dr_cap_mode_t {DR_CAP_PARALLEL, DR_CAP_CONST}.
- Shared IDCODE/USERCODE constants also go in as_pack, for use as CAP_VAL.
- Sub-module jtag_dr_len_chk holds the saturating shift counter and the length compare. It is instantiated only under JTAG_DR_LEN_CHECK_EN.
- The shift and update registers stay in the top module.

## Test plan
- Reset: WIDTH=8, RST_VAL=8'hA5, assert trst_i mid-shift -> par_o=8'hA5, tdo_o=0, upd_o=0, len_err_o=0.
- Capture/shift: WIDTH=8, par_i=8'h3C, capture, then 8 shifts with tdi=1,0,1,0,1,0,1,0 -> tdo sequence 0,0,1,1,1,1,0,0; update -> par_o=8'h55, one upd_o pulse.
- Constant mode: WIDTH=32, DR_CAP_CONST, CAP_VAL=32'h1BA0_0477, capture plus 32 shifts -> tdo streams 32'h1BA0_0477 LSB first.
- Deselect: sel_i=0 during capture/shift/update strobes -> shift register and par_o unchanged, upd_o=0.
- Length check (macro on): capture, 7 shifts on WIDTH=8, update -> par_o unchanged, len_err_o=1. Then 9 shifts (after a fresh capture) -> same result. Then capture -> len_err_o=0.
- Simultaneous strobes: capture_dr_i and shift_dr_i high together -> capture occurs, counter=0.
